cpu86_exec_regfile_wr_arb: RTL
==============================

CPU86_EXEC_REGFILE_WR_ARB -- requirements
Module: cpu86_exec_regfile_wr_arb

Interface
REQ-001 Parameter NREQ, default 4, number of execution-unit requesters (0=ALU, 1=MULDIV, 2=STACKU, 3=STR).
REQ-002 Parameter MAX_BURST, default 8, maximum beats per locked burst (POPA length).
REQ-003 clk  in  1  clock; all logic rising-edge.
REQ-004 resetn  in  1  reset, synchronous, active-low.
REQ-005 req_valid  in  NREQ  per-requester write request.
REQ-006 req_ready  out  NREQ  per-requester accept; a beat transfers when valid and ready are both 1.
REQ-007 req_reg  in  4*NREQ  target register code: AX=0, DX=1, CX=2, BX=3, BP=4, SI=5, DI=6, SP=7, ES=8, CS=9, SS=10, DS=11, FL=12, ZERO=13.
REQ-008 req_data  in  16*NREQ  write data.
REQ-009 req_mask  in  2*NREQ  byte enables: bit0 = low byte, bit1 = high byte.
REQ-010 req_last  in  NREQ  final beat of the requester's burst; a single write has last=1.
REQ-011 wr_valid  out  1  register-file write beat valid.
REQ-012 wr_ready  in  1  register-file accept.
REQ-013 wr_reg / wr_data / wr_mask  out  4 / 16 / 2  forwarded beat.
REQ-014 grant_id  out  2  index of the currently granted requester.
REQ-015 busy  out  1  1 while in BURST state or while wr_valid=1.
REQ-016 err  out  1  sticky error flag.

Function
REQ-017 The block SHALL have two states: IDLE (no owner) and BURST (owner locked until its last beat is accepted).
REQ-018 In IDLE, the block SHALL grant by round-robin starting from rr_ptr; the grant SHALL be combinational, in the same cycle as req_valid.
REQ-019 An accepted beat with req_last=0 SHALL move IDLE->BURST; only the owner SHALL receive req_ready in BURST.
REQ-020 An accepted beat with req_last=1 SHALL return to IDLE and set rr_ptr = (owner+1) mod NREQ.
REQ-021 req_ready[g] SHALL equal the grant AND (wr_valid==0 OR wr_ready==1); a new beat can therefore be accepted every cycle while wr_ready=1.
REQ-022 An accepted beat SHALL appear on wr_* exactly 1 cycle later and SHALL hold stable until wr_ready=1.
REQ-023 Beats with req_reg=ZERO or req_mask=00 SHALL be accepted and counted toward the burst, but SHALL NOT assert wr_valid.
REQ-024 Beats with req_reg 14 or 15 SHALL be accepted and dropped, and SHALL set err.
REQ-025 A burst beat counter (3 bits wide for MAX_BURST=8) SHALL count accepted beats. If MAX_BURST beats are accepted without req_last, the block SHALL set err and force the return to IDLE, with rr_ptr advanced as in REQ-020.
REQ-026 While the owner's req_valid is 0 in BURST, the block SHALL stay in BURST and SHALL grant no other requester.
REQ-027 When wr_valid=1, wr_ready=1 and a new beat is accepted in the same cycle, the output register SHALL load the new beat with no bubble.
REQ-028 grant_id SHALL show the owner in BURST, the round-robin winner in IDLE when any request is present, and rr_ptr otherwise.

Reset
REQ-029 When resetn=0 at a clock edge, the block SHALL reset to: state=IDLE, rr_ptr=0, wr_valid=0, wr_reg=0, wr_data=0, wr_mask=0, beat counter=0, err=0.
REQ-030 While resetn=0, req_ready SHALL be all zeros.
REQ-031 A reset during BURST SHALL drop the burst and any pending output beat, with no further wr_valid.

Verification
REQ-032 Case 1, single write: req_valid=0001, reg=AX, data=0x1234, mask=11, last=1, wr_ready=1 -> next cycle wr_valid=1, wr_reg=0, wr_data=0x1234; afterwards rr_ptr=1.
REQ-033 Case 2, round-robin: all four requesters request continuously with last=1 -> grant order 0,1,2,3,0 on consecutive cycles.
REQ-034 Case 3, POPA burst: requester 2 sends 8 beats (DI, SI, BP, ZERO, BX, DX, CX, AX) with last on beat 8, while requester 0 also requests -> requester 0 is not granted until beat 8 is accepted; exactly 7 wr_valid beats are issued (the ZERO beat produces none).
REQ-035 Case 4, backpressure: wr_ready=0 for 3 cycles with a beat pending -> wr_* stay stable and req_ready=0; when wr_ready returns to 1, transfer resumes with no lost or duplicated beat.
REQ-036 Case 5, overrun: requester 1 sends 8 beats with last=0 -> err=1 after the 8th accepted beat, state returns to IDLE, grant moves to requester 2.
REQ-037 Case 6, reset mid-burst: resetn=0 after beat 3 of a burst -> next cycle wr_valid=0, err=0, grant_id=0, state=IDLE.

Source files
------------

// File: rtl/cpu86_exec_regfile_wr_arb.sv
// rtl/cpu86_exec_regfile_wr_arb.sv - register-file write arbiter with round-robin grant and locked bursts
module cpu86_exec_regfile_wr_arb #(
  parameter int NREQ      = 4,
  parameter int MAX_BURST = 8
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [4*NREQ-1:0]    req_reg,
  input  logic [16*NREQ-1:0]   req_data,
  input  logic [2*NREQ-1:0]    req_mask,
  input  logic [NREQ-1:0]      req_last,
  output logic                 wr_valid,
  input  logic                 wr_ready,
  output logic [3:0]           wr_reg,
  output logic [15:0]          wr_data,
  output logic [1:0]           wr_mask,
  output logic [1:0]           grant_id,
  output logic                 busy,
  output logic                 err
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  typedef enum logic {ST_IDLE, ST_BURST} state_t;

  state_t          r_state, w_state_nxt;
  logic [IW-1:0]   r_owner, w_owner_nxt;
  logic [IW-1:0]   r_rr_ptr, w_rr_nxt;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic            r_err, w_err_nxt;
  logic            r_wr_valid;
  logic [3:0]      r_wr_reg;
  logic [15:0]     r_wr_data;
  logic [1:0]      r_wr_mask;

  logic [IW-1:0]   w_winner, w_idx, w_grant, w_grant_inc;
  logic            w_any, w_gvalid, w_out_free, w_accept;
  logic            w_bad, w_write, w_full, w_end;
  logic [3:0]      w_reg;
  logic [15:0]     w_data;
  logic [1:0]      w_mask;

  // Round-robin search: first valid requester at or after rr_ptr; rr_ptr itself when none.
  always_comb begin
    w_any    = 1'b0;
    w_winner = r_rr_ptr;
    w_idx    = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_idx = IW'((int'(r_rr_ptr) + i) % NREQ);
      if (!w_any && req_valid[w_idx]) begin
        w_any    = 1'b1;
        w_winner = w_idx;
      end
    end
  end

  // The burst owner is locked; otherwise the round-robin winner holds the grant.
  assign w_grant     = (r_state == ST_BURST) ? r_owner : w_winner;
  assign w_gvalid    = (r_state == ST_BURST) ? req_valid[r_owner] : w_any;
  assign w_grant_inc = (w_grant == IW'(NREQ - 1)) ? '0 : w_grant + 1'b1;
  assign w_out_free  = !r_wr_valid || wr_ready;
  assign w_accept    = resetn && w_gvalid && w_out_free;

  assign w_reg   = req_reg[4*int'(w_grant) +: 4];
  assign w_data  = req_data[16*int'(w_grant) +: 16];
  assign w_mask  = req_mask[2*int'(w_grant) +: 2];
  assign w_bad   = (w_reg >= 4'd14);
  assign w_write = !w_bad && (w_reg != 4'd13) && (w_mask != 2'b00);
  assign w_full  = (r_cnt == CW'(MAX_BURST - 1));
  assign w_end   = req_last[w_grant] || w_full;

  // Ready goes only to the granted requester, and only when the output slot can take a beat.
  always_comb begin
    req_ready = '0;
    if (resetn && w_out_free && ((r_state == ST_BURST) || w_any))
      req_ready[w_grant] = 1'b1;
  end

  // Next-state: lock owner on a non-last beat, release and advance rr_ptr on last beat or overrun.
  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_rr_nxt    = r_rr_ptr;
    w_cnt_nxt   = r_cnt;
    w_err_nxt   = r_err;
    if (w_accept) begin
      if (w_bad)
        w_err_nxt = 1'b1;
      if (w_end) begin
        w_state_nxt = ST_IDLE;
        w_rr_nxt    = w_grant_inc;
        w_cnt_nxt   = '0;
        if (!req_last[w_grant])
          w_err_nxt = 1'b1;
      end else begin
        w_state_nxt = ST_BURST;
        w_owner_nxt = w_grant;
        w_cnt_nxt   = r_cnt + 1'b1;
      end
    end
  end

  // Arbitration state register.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state  <= ST_IDLE;
      r_owner  <= '0;
      r_rr_ptr <= '0;
      r_cnt    <= '0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_owner  <= w_owner_nxt;
      r_rr_ptr <= w_rr_nxt;
      r_cnt    <= w_cnt_nxt;
      r_err    <= w_err_nxt;
    end
  end

  // Output slot: loads an accepted writable beat, holds until the register file takes it.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_wr_valid <= 1'b0;
      r_wr_reg   <= '0;
      r_wr_data  <= '0;
      r_wr_mask  <= '0;
    end else if (w_accept) begin
      r_wr_valid <= w_write;
      if (w_write) begin
        r_wr_reg  <= w_reg;
        r_wr_data <= w_data;
        r_wr_mask <= w_mask;
      end
    end else if (wr_ready) begin
      r_wr_valid <= 1'b0;
    end
  end

  assign wr_valid = r_wr_valid;
  assign wr_reg   = r_wr_reg;
  assign wr_data  = r_wr_data;
  assign wr_mask  = r_wr_mask;
  assign grant_id = 2'(w_grant);
  assign busy     = (r_state == ST_BURST) || r_wr_valid;
  assign err      = r_err;

endmodule
